// File: rtl/divisor_sequencial.sv
// Sequential restoring divider: 10-bit dividend / 5-bit divisor, one quotient bit per clock.
// Results are held in output registers between done pulses; a zero divisor short-circuits to FIM.
module divisor_sequencial #(
  parameter int N_A = 10,
  parameter int N_B = 5
) (
  input  logic           CLOCK_50,
  input  logic           reset_n,
  input  logic           start,
  input  logic [N_A-1:0] dividendo,
  input  logic [N_B-1:0] divisor,
  output logic           busy,
  output logic           done,
  output logic [N_A-1:0] quociente,
  output logic [N_B-1:0] resto,
  output logic           div_zero
);

  localparam int CNT_W = $clog2(N_A + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N_A);

  typedef enum logic [1:0] {IDLE, RUN, FIM} state_t;

  state_t           state_q, state_d;
  logic [N_B:0]     p_q, p_d;
  logic [N_A-1:0]   q_q, q_d;
  logic [N_B-1:0]   dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [N_A-1:0]   quo_q, quo_d;
  logic [N_B-1:0]   rem_q, rem_d;
  logic             dz_q, dz_d;

  logic [N_B:0]     p_shift;
  logic [N_B+1:0]   trial;

  always_comb begin
    p_shift = {p_q[N_B-1:0], q_q[N_A-1]};
    // Extra top bit of the trial difference acts as the borrow / sign.
    trial   = {1'b0, p_shift} - {2'b00, dvs_q};

    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          dvs_d   = divisor;
          p_d     = '0;
          q_d     = dividendo;
          cnt_d   = CNT_INIT;
          busy_d  = 1'b1;
          zero_d  = (divisor == '0);
          state_d = (divisor == '0) ? FIM : RUN;
        end
      end
      RUN: begin
        if (!trial[N_B+1]) begin
          p_d = trial[N_B:0];
          q_d = {q_q[N_A-2:0], 1'b1};
        end else begin
          p_d = p_shift;
          q_d = {q_q[N_A-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = FIM;
      end
      FIM: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (zero_q) begin
          quo_d = '1;
          rem_d = '0;
          dz_d  = 1'b1;
        end else begin
          quo_d = q_q;
          rem_d = p_q[N_B-1:0];
          dz_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quociente = quo_q;
  assign resto     = rem_q;
  assign div_zero  = dz_q;

endmodule
